// File: rtl/soc_bus_decoder.sv
// Single-master to four-slave bus decoder: latches a request, routes it by addr[31:28],
// waits for the slave ack (or a timeout) and returns a one-cycle ack with read data.
module soc_bus_decoder #(
  parameter logic [3:0]  S0_PREFIX      = 4'h0,
  parameter logic [3:0]  S1_PREFIX      = 4'h1,
  parameter logic [3:0]  S2_PREFIX      = 4'hE,
  parameter logic [3:0]  S3_PREFIX      = 4'hF,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         ce_i,
  input  logic         sel_i,
  input  logic [31:0]  addr_i,
  input  logic         we_i,
  input  logic [3:0]   wr_mask_i,
  input  logic [31:0]  data_i,
  output logic [31:0]  data_o,
  output logic         ack_o,
  output logic [3:0]   s_sel_o,
  output logic [31:0]  s_addr_o,
  output logic         s_we_o,
  output logic [3:0]   s_wr_mask_o,
  output logic [31:0]  s_data_o,
  input  logic [127:0] s_data_i,
  input  logic [3:0]   s_ack_i,
  output logic         err_o,
  output logic [31:0]  err_addr_o,
  input  logic         err_clr_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [3:0]  hit;
  logic        slv_ack;
  logic [31:0] slv_rdata;
  logic        err_evt;
  logic [31:0] err_evt_addr;

  // Priority decode: a duplicated prefix resolves to the lowest slave index.
  always_comb begin
    hit = 4'b0000;
    if (addr_i[31:28] == S0_PREFIX)      hit = 4'b0001;
    else if (addr_i[31:28] == S1_PREFIX) hit = 4'b0010;
    else if (addr_i[31:28] == S2_PREFIX) hit = 4'b0100;
    else if (addr_i[31:28] == S3_PREFIX) hit = 4'b1000;
  end

  assign slv_ack = |(s_ack_i & sel_q);

  always_comb begin
    slv_rdata = 32'h0;
    unique case (sel_q)
      4'b0001: slv_rdata = s_data_i[31:0];
      4'b0010: slv_rdata = s_data_i[63:32];
      4'b0100: slv_rdata = s_data_i[95:64];
      4'b1000: slv_rdata = s_data_i[127:96];
      default: slv_rdata = 32'h0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    we_d         = we_q;
    mask_d       = mask_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_evt      = 1'b0;
    err_evt_addr = addr_q;

    unique case (state_q)
      StIdle: begin
        if (sel_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          mask_d  = wr_mask_i;
          wdata_d = data_i;
          if (|hit) begin
            sel_d   = hit;
            cnt_d   = 16'h0;
            state_d = StAccess;
          end else begin
            err_evt      = 1'b1;
            err_evt_addr = addr_i;
            rdata_d      = we_i ? 32'h0 : ERR_DATA;
            state_d      = StResp;
          end
        end
      end
      StAccess: begin
        if (slv_ack) begin
          rdata_d = we_q ? 32'h0 : slv_rdata;
          sel_d   = 4'b0000;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          err_evt = 1'b1;
          rdata_d = we_q ? 32'h0 : ERR_DATA;
          sel_d   = 4'b0000;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A new error beats a simultaneous clear; otherwise the first error address sticks.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_evt) begin
      if (!err_q || err_clr_i) begin
        err_d      = 1'b1;
        err_addr_d = err_evt_addr;
      end
    end else if (err_clr_i) begin
      err_d      = 1'b0;
      err_addr_d = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      sel_q      <= 4'b0000;
      addr_q     <= 32'h0;
      we_q       <= 1'b0;
      mask_q     <= 4'b0000;
      wdata_q    <= 32'h0;
      cnt_q      <= 16'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else if (ce_i) begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign ack_o       = (state_q == StResp);
  assign data_o      = rdata_q;
  assign s_sel_o     = sel_q;
  assign s_addr_o    = addr_q;
  assign s_we_o      = we_q;
  assign s_wr_mask_o = mask_q;
  assign s_data_o    = wdata_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_soc_bus_decoder.sv
// Directed bench for soc_bus_decoder: one instance with the default timeout and one with
// TIMEOUT_CYCLES=4, sharing the master/slave stimulus.
module tb_soc_bus_decoder;

  logic         clk = 1'b0;
  logic         reset_i, ce_i, sel_i, we_i, err_clr_i;
  logic [31:0]  addr_i, data_i;
  logic [3:0]   wr_mask_i, s_ack_i;
  logic [127:0] s_data_i;

  logic [31:0] data_o, s_addr_o, s_data_o, err_addr_o;
  logic        ack_o, s_we_o, err_o;
  logic [3:0]  s_sel_o, s_wr_mask_o;

  logic [31:0] t_data_o, t_s_addr_o, t_s_data_o, t_err_addr_o;
  logic        t_ack_o, t_s_we_o, t_err_o;
  logic [3:0]  t_s_sel_o, t_s_wr_mask_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_bus_decoder dut (
    .clk(clk), .reset_i(reset_i), .ce_i(ce_i), .sel_i(sel_i), .addr_i(addr_i), .we_i(we_i),
    .wr_mask_i(wr_mask_i), .data_i(data_i), .data_o(data_o), .ack_o(ack_o),
    .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wr_mask_o(s_wr_mask_o),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i), .err_o(err_o),
    .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
  );

  soc_bus_decoder #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .reset_i(reset_i), .ce_i(ce_i), .sel_i(sel_i), .addr_i(addr_i), .we_i(we_i),
    .wr_mask_i(wr_mask_i), .data_i(data_i), .data_o(t_data_o), .ack_o(t_ack_o),
    .s_sel_o(t_s_sel_o), .s_addr_o(t_s_addr_o), .s_we_o(t_s_we_o),
    .s_wr_mask_o(t_s_wr_mask_o), .s_data_o(t_s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .err_o(t_err_o), .err_addr_o(t_err_addr_o), .err_clr_i(err_clr_i)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ce_i = 1'b1; sel_i = 1'b0; we_i = 1'b0; err_clr_i = 1'b0;
    addr_i = 32'h0; data_i = 32'h0; wr_mask_i = 4'h0; s_ack_i = 4'h0; s_data_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    step();
  endtask

  task automatic request(input logic [31:0] a, input logic w, input logic [3:0] m,
                         input logic [31:0] d);
    sel_i = 1'b1; addr_i = a; we_i = w; wr_mask_i = m; data_i = d;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    idle_inputs();
    #1;
    n_checks++;
    if ({ack_o, s_sel_o, err_o, s_we_o, s_wr_mask_o} !== 11'h0) begin
      n_fail++; $display("FAIL reset_ctrl got %h want 0", {ack_o, s_sel_o, err_o, s_we_o, s_wr_mask_o});
    end
    n_checks++;
    if ({data_o, s_addr_o, s_data_o, err_addr_o} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", {data_o, s_addr_o, s_data_o, err_addr_o});
    end
    step();
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_read_s0();
    do_reset();
    request(32'h00000100, 1'b0, 4'h0, 32'h0);
    step(); // cycle 1
    sel_i = 1'b0;
    n_checks++;
    if (s_sel_o !== 4'b0001) begin n_fail++; $display("FAIL rd0_sel got %b want 0001", s_sel_o); end
    n_checks++;
    if (ack_o !== 1'b0) begin n_fail++; $display("FAIL rd0_early_ack got %b want 0", ack_o); end
    s_ack_i = 4'b0001; s_data_i[31:0] = 32'h12345678;
    step(); // cycle 2
    s_ack_i = 4'h0; s_data_i = '0;
    n_checks++;
    if (ack_o !== 1'b1) begin n_fail++; $display("FAIL rd0_ack got %b want 1", ack_o); end
    n_checks++;
    if (data_o !== 32'h12345678) begin n_fail++; $display("FAIL rd0_data got %h want 12345678", data_o); end
    n_checks++;
    if (s_sel_o !== 4'b0000) begin n_fail++; $display("FAIL rd0_sel_drop got %b want 0000", s_sel_o); end
    step(); // cycle 3
    n_checks++;
    if (ack_o !== 1'b0) begin n_fail++; $display("FAIL rd0_ack_pulse got %b want 0", ack_o); end
    n_checks++;
    if (data_o !== 32'h12345678) begin n_fail++; $display("FAIL rd0_data_hold got %h want 12345678", data_o); end
    n_checks++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL rd0_err got %b want 0", err_o); end
  endtask

  task automatic test_write_s2();
    do_reset();
    request(32'hE0000004, 1'b1, 4'b0011, 32'hCAFEF00D);
    for (int c = 1; c <= 5; c++) begin
      step();
      sel_i = 1'b0; addr_i = 32'h0; we_i = 1'b0; wr_mask_i = 4'h0; data_i = 32'h0;
      n_checks++;
      if ({s_sel_o, s_addr_o, s_we_o, s_wr_mask_o, s_data_o} !== {4'b0100, 32'hE0000004, 1'b1, 4'b0011, 32'hCAFEF00D}) begin
        n_fail++;
        $display("FAIL wr2_s_outs cycle %0d got %b %h %b %b %h", c, s_sel_o, s_addr_o, s_we_o, s_wr_mask_o, s_data_o);
      end
      n_checks++;
      if (ack_o !== 1'b0) begin n_fail++; $display("FAIL wr2_early_ack cycle %0d got %b want 0", c, ack_o); end
      if (c == 5) begin s_ack_i = 4'b0100; s_data_i[95:64] = 32'h11112222; end
      else s_ack_i = 4'b0001; // unselected slave ack must be ignored
    end
    step(); // cycle 6
    s_ack_i = 4'h0; s_data_i = '0;
    n_checks++;
    if (ack_o !== 1'b1) begin n_fail++; $display("FAIL wr2_ack got %b want 1", ack_o); end
    n_checks++;
    if (data_o !== 32'h0) begin n_fail++; $display("FAIL wr2_data got %h want 0", data_o); end
    n_checks++;
    if (s_addr_o !== 32'hE0000004) begin n_fail++; $display("FAIL wr2_addr_hold got %h want e0000004", s_addr_o); end
  endtask

  task automatic test_unmapped();
    do_reset();
    request(32'h50000000, 1'b0, 4'h0, 32'h0);
    step(); // cycle 1
    sel_i = 1'b0;
    n_checks++;
    if (s_sel_o !== 4'b0000) begin n_fail++; $display("FAIL unm_sel got %b want 0000", s_sel_o); end
    n_checks++;
    if (ack_o !== 1'b1) begin n_fail++; $display("FAIL unm_ack got %b want 1", ack_o); end
    n_checks++;
    if (data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL unm_data got %h want deadbeef", data_o); end
    n_checks++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL unm_err got %b want 1", err_o); end
    n_checks++;
    if (err_addr_o !== 32'h50000000) begin n_fail++; $display("FAIL unm_err_addr got %h want 50000000", err_addr_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    request(32'hF0000000, 1'b0, 4'h0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      sel_i = 1'b0;
      n_checks++;
      if ({t_s_sel_o, t_ack_o} !== {4'b1000, 1'b0}) begin
        n_fail++; $display("FAIL to_sel cycle %0d got sel %b ack %b want 1000 0", c, t_s_sel_o, t_ack_o);
      end
    end
    step(); // cycle 5
    n_checks++;
    if ({t_s_sel_o, t_ack_o} !== {4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL to_ack got sel %b ack %b want 0000 1", t_s_sel_o, t_ack_o);
    end
    n_checks++;
    if (t_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_data got %h want deadbeef", t_data_o); end
    n_checks++;
    if ({t_err_o, t_err_addr_o} !== {1'b1, 32'hF0000000}) begin
      n_fail++; $display("FAIL to_err got %b %h want 1 f0000000", t_err_o, t_err_addr_o);
    end

    // Ack on the last allowed cycle beats the timeout.
    do_reset();
    request(32'hF0000000, 1'b0, 4'h0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      sel_i = 1'b0;
      if (c == 4) begin s_ack_i = 4'b1000; s_data_i[127:96] = 32'hA5A50003; end
    end
    step(); // cycle 5
    s_ack_i = 4'h0; s_data_i = '0;
    n_checks++;
    if ({t_ack_o, t_data_o} !== {1'b1, 32'hA5A50003}) begin
      n_fail++; $display("FAIL to_late_ack got %b %h want 1 a5a50003", t_ack_o, t_data_o);
    end
    n_checks++;
    if (t_err_o !== 1'b0) begin n_fail++; $display("FAIL to_late_err got %b want 0", t_err_o); end
  endtask

  task automatic test_err_status();
    do_reset();
    request(32'h50000000, 1'b0, 4'h0, 32'h0);
    step(); // cycle 1: ack, err latched
    sel_i = 1'b0;
    step(); // earliest back-to-back request
    request(32'h60000000, 1'b1, 4'hF, 32'h1);
    step();
    sel_i = 1'b0;
    n_checks++;
    if ({ack_o, data_o} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL b2b_ack got %b %h want 1 0", ack_o, data_o);
    end
    n_checks++;
    if ({err_o, err_addr_o} !== {1'b1, 32'h50000000}) begin
      n_fail++; $display("FAIL err_sticky got %b %h want 1 50000000", err_o, err_addr_o);
    end
    step();
    request(32'h70000000, 1'b0, 4'h0, 32'h0);
    err_clr_i = 1'b1;
    step();
    sel_i = 1'b0; err_clr_i = 1'b0;
    n_checks++;
    if ({err_o, err_addr_o} !== {1'b1, 32'h70000000}) begin
      n_fail++; $display("FAIL err_clr_race got %b %h want 1 70000000", err_o, err_addr_o);
    end
    step();
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    n_checks++;
    if ({err_o, err_addr_o} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL err_clr got %b %h want 0 0", err_o, err_addr_o);
    end
  endtask

  task automatic test_ce_gating();
    do_reset();
    request(32'h00000200, 1'b0, 4'h0, 32'h0);
    step(); // ce cycle 1
    sel_i = 1'b0; ce_i = 1'b0;
    step(); // stalled edge
    n_checks++;
    if ({s_sel_o, ack_o} !== {4'b0001, 1'b0}) begin
      n_fail++; $display("FAIL ce_stall1 got %b %b want 0001 0", s_sel_o, ack_o);
    end
    ce_i = 1'b1;
    step(); // ce cycle 2
    s_ack_i = 4'b0001; s_data_i[31:0] = 32'h0BADF00D; ce_i = 1'b0;
    step(); // stalled edge, ack not yet sampled
    n_checks++;
    if ({s_sel_o, ack_o} !== {4'b0001, 1'b0}) begin
      n_fail++; $display("FAIL ce_stall2 got %b %b want 0001 0", s_sel_o, ack_o);
    end
    ce_i = 1'b1;
    step(); // ce cycle 3: response
    s_ack_i = 4'h0; s_data_i = '0; ce_i = 1'b0;
    n_checks++;
    if ({ack_o, data_o} !== {1'b1, 32'h0BADF00D}) begin
      n_fail++; $display("FAIL ce_ack got %b %h want 1 0badf00d", ack_o, data_o);
    end
    step(); // stalled in response
    n_checks++;
    if (ack_o !== 1'b1) begin n_fail++; $display("FAIL ce_ack_hold got %b want 1", ack_o); end
    ce_i = 1'b1;
    step();
    n_checks++;
    if (ack_o !== 1'b0) begin n_fail++; $display("FAIL ce_ack_end got %b want 0", ack_o); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    request(32'h10000040, 1'b0, 4'h0, 32'h0);
    step();
    sel_i = 1'b0;
    n_checks++;
    if (s_sel_o !== 4'b0010) begin n_fail++; $display("FAIL rst_mid_sel got %b want 0010", s_sel_o); end
    #2;
    reset_i = 1'b1;
    #1;
    n_checks++;
    if ({s_sel_o, ack_o} !== {4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid_async got %b %b want 0000 0", s_sel_o, ack_o);
    end
    step();
    reset_i = 1'b0;
    step();
    request(32'h10000080, 1'b0, 4'h0, 32'h0);
    step();
    sel_i = 1'b0; s_ack_i = 4'b0010; s_data_i[63:32] = 32'h5A5A1234;
    step();
    s_ack_i = 4'h0; s_data_i = '0;
    n_checks++;
    if ({ack_o, data_o} !== {1'b1, 32'h5A5A1234}) begin
      n_fail++; $display("FAIL rst_mid_next got %b %h want 1 5a5a1234", ack_o, data_o);
    end
  endtask

  initial begin
    test_reset();
    test_read_s0();
    test_write_s2();
    test_unmapped();
    test_timeout();
    test_err_status();
    test_ce_gating();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
